hex_display_arbiter: RTL and testbench

Shares the single four-digit hex display (the four 7-segment decoders fed by a 16-bit value) between two requesters: A (CPU register output) and B (keyboard scan-code path). Each requester posts a 16-bit value with a req/ack handshake. The arbiter grants round-robin, latches the granted value onto the display bus, and holds it for a minimum dwell time so a human can read it. It sits between the CPU/keyboard logic and the hex decoders in the top-level wrapper.

---
 rtl/hex_display_arbiter.sv | 96 +++++++++
 tb/tb_hex_display_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - round-robin arbiter sharing one hex display between two requesters
module hex_display_arbiter #(
    parameter int WIDTH       = 16,
    parameter int HOLD_CYCLES = 10000000
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic [WIDTH-1:0] disp_value,
    output logic             disp_src,
    output logic             disp_valid,
    output logic             busy
);

    localparam int CNT_W = ($clog2(HOLD_CYCLES + 1) > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_src;
    logic             r_ack_a;
    logic             r_ack_b;
    logic [WIDTH-1:0] r_disp_value;
    logic             r_disp_src;
    logic             r_disp_valid;
    logic             r_busy;

    logic w_elig_a;
    logic w_elig_b;
    logic w_can_grant;
    logic w_grant;
    logic w_pick_b;

    // A request is not eligible while its own ack is high, so a requester that
    // has not yet dropped req cannot be captured twice.
    always_comb begin
        w_elig_a    = req_a & ~r_ack_a;
        w_elig_b    = req_b & ~r_ack_b;
        w_can_grant = (r_state == ST_IDLE) || (r_cnt == '0);
        w_grant     = w_can_grant & (w_elig_a | w_elig_b);
        w_pick_b    = w_elig_b & (~w_elig_a | ~r_last_src);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_src   <= 1'b1;
            r_ack_a      <= 1'b0;
            r_ack_b      <= 1'b0;
            r_disp_value <= '0;
            r_disp_src   <= 1'b0;
            r_disp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            if (w_grant) begin
                r_state      <= ST_HOLD;
                r_cnt        <= RELOAD;
                r_last_src   <= w_pick_b;
                r_ack_a      <= ~w_pick_b;
                r_ack_b      <= w_pick_b;
                r_disp_value <= w_pick_b ? data_b : data_a;
                r_disp_src   <= w_pick_b;
                r_disp_valid <= 1'b1;
                r_busy       <= 1'b1;
            end else if (r_state == ST_HOLD) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign ack_a      = r_ack_a;
    assign ack_b      = r_ack_b;
    assign disp_value = r_disp_value;
    assign disp_src   = r_disp_src;
    assign disp_valid = r_disp_valid;
    assign busy       = r_busy;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb/tb_hex_display_arbiter.sv - scoreboard bench for hex_display_arbiter
module tb_hex_display_arbiter;

    typedef struct {
        logic        src;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        req_a4 = 1'b0, req_b4 = 1'b0;
    logic [15:0] data_a4 = '0, data_b4 = '0;
    logic        ack_a4, ack_b4, disp_src4, disp_valid4, busy4;
    logic [15:0] disp_value4;

    logic        req_a1 = 1'b0, req_b1 = 1'b0;
    logic [15:0] data_a1 = '0, data_b1 = '0;
    logic        ack_a1, ack_b1, disp_src1, disp_valid1, busy1;
    logic [15:0] disp_value1;

    exp_t q4[$];
    exp_t q1[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    hex_display_arbiter #(.WIDTH(16), .HOLD_CYCLES(4)) dut4 (
        .Clk(Clk), .Rst(Rst),
        .req_a(req_a4), .data_a(data_a4), .req_b(req_b4), .data_b(data_b4),
        .ack_a(ack_a4), .ack_b(ack_b4), .disp_value(disp_value4),
        .disp_src(disp_src4), .disp_valid(disp_valid4), .busy(busy4)
    );

    hex_display_arbiter #(.WIDTH(16), .HOLD_CYCLES(1)) dut1 (
        .Clk(Clk), .Rst(Rst),
        .req_a(req_a1), .data_a(data_a1), .req_b(req_b1), .data_b(data_b1),
        .ack_a(ack_a1), .ack_b(ack_b1), .disp_value(disp_value1),
        .disp_src(disp_src1), .disp_valid(disp_valid1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requesters drop req on the cycle their ack is seen.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (ack_a4) req_a4 = 1'b0;
        if (ack_b4) req_b4 = 1'b0;
    endtask

    always @(posedge Clk) begin
        #1;
        if (ack_a4 || ack_b4) begin
            if (q4.size() == 0) begin
                check("dut4_unexpected_ack", {30'd0, ack_b4, ack_a4}, 32'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("dut4_ack_src", {31'd0, ack_b4}, {31'd0, e.src});
                check("dut4_one_ack", {31'd0, ack_a4 & ack_b4}, 32'd0);
                check("dut4_src", {31'd0, disp_src4}, {31'd0, e.src});
                check("dut4_value", {16'd0, disp_value4}, {16'd0, e.val});
                check("dut4_cycle", cyc, e.cyc);
                check("dut4_valid_busy", {30'd0, disp_valid4, busy4}, 32'd3);
            end
        end
    end

    always @(posedge Clk) begin
        #1;
        if (ack_a1 || ack_b1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_ack", {30'd0, ack_b1, ack_a1}, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1_ack_src", {30'd0, ack_b1, ack_a1}, {30'd0, e.src, ~e.src});
                check("dut1_value", {16'd0, disp_value1}, {16'd0, e.val});
                check("dut1_cycle", cyc, e.cyc);
                check("dut1_busy", {31'd0, busy1}, 32'd1);
            end
        end
    end

    initial begin
        int e;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_valid", {31'd0, disp_valid4}, 32'd0);
        check("rst_value", {16'd0, disp_value4}, 32'd0);
        check("rst_busy_acks", {29'd0, busy4, ack_a4, ack_b4}, 32'd0);
        check("rst_src", {31'd0, disp_src4}, 32'd0);
        check("rst_valid1", {31'd0, disp_valid1}, 32'd0);
        Rst = 1'b1;
        tick();
        tick();

        // first grant, dwell, return to idle
        e = cyc;
        req_a4 = 1'b1; data_a4 = 16'h1234;
        q4.push_back('{1'b0, 16'h1234, e + 1});
        tick();
        repeat (3) tick();
        check("s1_busy_last", {31'd0, busy4}, 32'd1);
        tick();
        check("s1_busy_off", {31'd0, busy4}, 32'd0);
        check("s1_hold_value", {16'd0, disp_value4}, 32'h1234);
        check("s1_hold_valid", {30'd0, disp_valid4, disp_src4}, 32'd2);

        // tie from reset goes to A, then round robin
        Rst = 1'b0;
        #2;
        check("s2_rst_valid", {31'd0, disp_valid4}, 32'd0);
        Rst = 1'b1;
        tick();
        e = cyc;
        req_a4 = 1'b1; data_a4 = 16'hAAAA;
        req_b4 = 1'b1; data_b4 = 16'hBBBB;
        q4.push_back('{1'b0, 16'hAAAA, e + 1});
        q4.push_back('{1'b1, 16'hBBBB, e + 5});
        repeat (5) tick();
        req_a4 = 1'b1; data_a4 = 16'hA0A0;
        req_b4 = 1'b1; data_b4 = 16'hB0B0;
        q4.push_back('{1'b0, 16'hA0A0, e + 9});
        q4.push_back('{1'b1, 16'hB0B0, e + 13});
        repeat (8) tick();
        repeat (6) tick();

        // request waits through the dwell; a withdrawn request is never acked
        e = cyc;
        req_a4 = 1'b1; data_a4 = 16'h5555;
        q4.push_back('{1'b0, 16'h5555, e + 1});
        tick();
        req_b4 = 1'b1; data_b4 = 16'h0BEE;
        q4.push_back('{1'b1, 16'h0BEE, e + 5});
        tick();
        req_a4 = 1'b1; data_a4 = 16'h7777;
        tick();
        req_a4 = 1'b0;
        repeat (2) tick();
        repeat (6) tick();

        // asynchronous reset mid-dwell
        e = cyc;
        req_a4 = 1'b1; data_a4 = 16'h4321;
        q4.push_back('{1'b0, 16'h4321, e + 1});
        repeat (2) tick();
        req_b4 = 1'b1; data_b4 = 16'h0C0D;
        #3;
        Rst = 1'b0;
        #1;
        check("s4_rst_valid_busy", {30'd0, disp_valid4, busy4}, 32'd0);
        check("s4_rst_acks", {30'd0, ack_a4, ack_b4}, 32'd0);
        check("s4_rst_value", {16'd0, disp_value4}, 32'd0);
        #2;
        Rst = 1'b1;
        q4.push_back('{1'b1, 16'h0C0D, e + 3});
        tick();
        repeat (6) tick();

        // HOLD_CYCLES=1, continuous requester B with changing data
        e = cyc;
        req_b1 = 1'b1;
        data_b1 = 16'h0100 + e[15:0];
        for (int j = 0; j < 5; j++) begin
            logic [15:0] v;
            v = 16'h0100 + e[15:0] + 16'(2 * j);
            q1.push_back('{1'b1, v, e + 1 + 2 * j});
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            data_b1 = 16'h0100 + cyc[15:0];
        end
        req_b1 = 1'b0;
        repeat (4) tick();
        check("s5_final_value", {16'd0, disp_value1}, {16'd0, 16'h0100 + e[15:0] + 16'd8});
        check("s5_idle", {31'd0, busy1}, 32'd0);

        check("q4_drained", q4.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
